lsu_param: RTL and testbench

Parametrised load/store unit for one MiniGPU thread lane, successor to the fixed 8-bit LSU. It sits between the core's register file (rs/rt operands) and the memory controller. Memory traffic uses explicit valid/ready handshakes, and a programmable timeout turns a hung request into a reported error instead of a stalled core. Issue and retire are sequenced by the core's REQUEST and UPDATE states.

---
 rtl/lsu_pkg.sv | 16 +
 rtl/lsu_timeout_ctr.sv | 35 +++
 rtl/lsu_param.sv | 138 +++++++++++++
 tb/tb_lsu_param.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the parametrised MiniGPU load/store unit.
// Holds the LSU state values and the core pipeline states it reacts to.
package lsu_pkg;

  typedef enum logic [2:0] {
    LSU_IDLE       = 3'd0,
    LSU_REQUESTING = 3'd1,
    LSU_WAITING    = 3'd2,
    LSU_DONE       = 3'd3,
    LSU_ERROR      = 3'd4
  } lsu_state_e;

  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;

endpackage

// File: rtl/lsu_timeout_ctr.sv
// Saturating wait-cycle counter for the LSU handshake timeout.
// expired flags the increment that completes MAX consecutive waiting cycles.
module lsu_timeout_ctr #(
  parameter int MAX = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  localparam int CW = (MAX < 1) ? 1 : $clog2(MAX + 1);
  localparam logic [CW-1:0] SAT  = CW'(MAX);
  localparam logic [CW-1:0] LAST = (MAX == 0) ? '0 : CW'(MAX - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (enable) begin
      if (clear) begin
        count <= '0;
      end else if (inc && (count != SAT)) begin
        count <= count + CW'(1);
      end
    end
  end

  // A saturated count also reports expiry, so the counter can never sit past the limit.
  assign expired = (MAX != 0) && inc && (count >= LAST);

endmodule

// File: rtl/lsu_param.sv
// Parametrised load/store unit for one MiniGPU thread lane.
// Issues one valid/ready memory request per instruction, with an optional hang timeout.
module lsu_param
  import lsu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [2:0]        core_state,
  input  logic              mem_read_enable,
  input  logic              mem_write_enable,
  input  logic [DATA_W-1:0] rs_out,
  input  logic [DATA_W-1:0] rt_out,
  input  logic              mem_read_ready,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_write_ready,
  output logic              mem_read_valid,
  output logic [ADDR_W-1:0] mem_read_address,
  output logic              mem_write_valid,
  output logic [ADDR_W-1:0] mem_write_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [2:0]        lsu_state,
  output logic [DATA_W-1:0] lsu_out,
  output logic              lsu_error
);

  lsu_state_e state, next_state;
  logic       is_read;
  logic       accept_req, reject_req, complete, timed_out;
  logic       ctr_clear, ctr_inc, ctr_expired;
  logic       wait_ready;

  lsu_timeout_ctr #(.MAX(TIMEOUT)) u_timeout_ctr (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .clear   (ctr_clear),
    .inc     (ctr_inc),
    .expired (ctr_expired)
  );

  assign wait_ready = is_read ? mem_read_ready : mem_write_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LSU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ready is checked before the timeout so a late ready still completes normally.
  always_comb begin
    next_state = state;
    accept_req = 1'b0;
    reject_req = 1'b0;
    complete   = 1'b0;
    timed_out  = 1'b0;
    ctr_clear  = 1'b0;
    ctr_inc    = 1'b0;
    if (enable) begin
      case (state)
        LSU_IDLE: begin
          if (core_state == CORE_REQUEST) begin
            if (mem_read_enable ^ mem_write_enable) begin
              accept_req = 1'b1;
              next_state = LSU_REQUESTING;
            end else if (mem_read_enable && mem_write_enable) begin
              reject_req = 1'b1;
              next_state = LSU_ERROR;
            end
          end
        end
        LSU_REQUESTING: begin
          ctr_clear  = 1'b1;
          next_state = LSU_WAITING;
        end
        LSU_WAITING: begin
          if (wait_ready) begin
            complete   = 1'b1;
            next_state = LSU_DONE;
          end else begin
            ctr_inc = 1'b1;
            if (ctr_expired) begin
              timed_out  = 1'b1;
              next_state = LSU_ERROR;
            end
          end
        end
        LSU_DONE, LSU_ERROR: begin
          if (core_state == CORE_UPDATE) next_state = LSU_IDLE;
        end
        default: next_state = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_read           <= 1'b0;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
      lsu_error         <= 1'b0;
    end else begin
      if (accept_req) begin
        is_read   <= mem_read_enable;
        lsu_error <= 1'b0;
      end
      if (reject_req || timed_out) lsu_error <= 1'b1;
      if (enable && (state == LSU_REQUESTING)) begin
        if (is_read) begin
          mem_read_address <= rs_out[ADDR_W-1:0];
          mem_read_valid   <= 1'b1;
        end else begin
          mem_write_address <= rs_out[ADDR_W-1:0];
          mem_write_data    <= rt_out;
          mem_write_valid   <= 1'b1;
        end
      end
      if (complete || timed_out) begin
        mem_read_valid  <= 1'b0;
        mem_write_valid <= 1'b0;
      end
      if (complete && is_read) lsu_out <= mem_read_data;
    end
  end

  assign lsu_state = state;

endmodule

// File: tb/tb_lsu_param.sv
// Directed self-checking bench for lsu_param with an 8-bit datapath and a 4-cycle timeout.
module tb_lsu_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [2:0] core_state = 3'b000;
  logic       mem_read_enable = 1'b0;
  logic       mem_write_enable = 1'b0;
  logic [7:0] rs_out = 8'h00;
  logic [7:0] rt_out = 8'h00;
  logic       mem_read_ready = 1'b0;
  logic [7:0] mem_read_data = 8'h00;
  logic       mem_write_ready = 1'b0;
  logic       mem_read_valid;
  logic [7:0] mem_read_address;
  logic       mem_write_valid;
  logic [7:0] mem_write_address;
  logic [7:0] mem_write_data;
  logic [2:0] lsu_state;
  logic [7:0] lsu_out;
  logic       lsu_error;

  int pass_cnt = 0;
  int total_cnt = 0;

  lsu_param #(.DATA_W(8), .ADDR_W(8), .TIMEOUT(4)) dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .core_state        (core_state),
    .mem_read_enable   (mem_read_enable),
    .mem_write_enable  (mem_write_enable),
    .rs_out            (rs_out),
    .rt_out            (rt_out),
    .mem_read_ready    (mem_read_ready),
    .mem_read_data     (mem_read_data),
    .mem_write_ready   (mem_write_ready),
    .mem_read_valid    (mem_read_valid),
    .mem_read_address  (mem_read_address),
    .mem_write_valid   (mem_write_valid),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .lsu_state         (lsu_state),
    .lsu_out           (lsu_out),
    .lsu_error         (lsu_error)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents an instruction in REQUEST for one edge, then withdraws the decode inputs.
  task automatic issue(input logic re, input logic we, input logic [7:0] rs, input logic [7:0] rt);
    enable = 1'b1;
    core_state = 3'b011;
    mem_read_enable = re;
    mem_write_enable = we;
    rs_out = rs;
    rt_out = rt;
    tick();
    core_state = 3'b000;
    mem_read_enable = 1'b0;
    mem_write_enable = 1'b0;
  endtask

  task automatic retire();
    core_state = 3'b110;
    tick();
    core_state = 3'b000;
  endtask

  task automatic test_reset();
    #3;
    total_cnt++; if (lsu_state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", lsu_state); else pass_cnt++;
    total_cnt++; if ({mem_read_valid, mem_write_valid, lsu_error} !== 3'b000) $display("[TB] FAIL reset_flags: got %b expected 000", {mem_read_valid, mem_write_valid, lsu_error}); else pass_cnt++;
    total_cnt++; if ({mem_read_address, mem_write_address, mem_write_data, lsu_out} !== 32'h0) $display("[TB] FAIL reset_data: got %h expected 0", {mem_read_address, mem_write_address, mem_write_data, lsu_out}); else pass_cnt++;
    #4 reset = 1'b1;
    tick();
    total_cnt++; if (lsu_state !== 3'd0) $display("[TB] FAIL idle_after_reset: got %0d expected 0", lsu_state); else pass_cnt++;
  endtask

  task automatic test_load();
    issue(1'b1, 1'b0, 8'h2A, 8'h00);
    total_cnt++; if (lsu_state !== 3'd1) $display("[TB] FAIL load_requesting: got %0d expected 1", lsu_state); else pass_cnt++;
    tick();
    rs_out = 8'h77;
    total_cnt++; if ({lsu_state, mem_read_valid, mem_read_address} !== {3'd2, 1'b1, 8'h2A}) $display("[TB] FAIL load_issue: got %h expected %h", {lsu_state, mem_read_valid, mem_read_address}, {3'd2, 1'b1, 8'h2A}); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({lsu_state, mem_read_valid, mem_read_address} !== {3'd2, 1'b1, 8'h2A}) $display("[TB] FAIL load_hold_%0d: got %h expected %h", i, {lsu_state, mem_read_valid, mem_read_address}, {3'd2, 1'b1, 8'h2A}); else pass_cnt++;
    end
    mem_read_ready = 1'b1;
    mem_read_data = 8'h5C;
    tick();
    mem_read_ready = 1'b0;
    mem_read_data = 8'h00;
    total_cnt++; if ({lsu_state, mem_read_valid, lsu_out} !== {3'd3, 1'b0, 8'h5C}) $display("[TB] FAIL load_done: got %h expected %h", {lsu_state, mem_read_valid, lsu_out}, {3'd3, 1'b0, 8'h5C}); else pass_cnt++;
    tick();
    total_cnt++; if (lsu_state !== 3'd3) $display("[TB] FAIL load_done_hold: got %0d expected 3", lsu_state); else pass_cnt++;
    retire();
    total_cnt++; if (lsu_state !== 3'd0) $display("[TB] FAIL load_retire: got %0d expected 0", lsu_state); else pass_cnt++;
  endtask

  task automatic test_store();
    issue(1'b0, 1'b1, 8'h10, 8'hEE);
    tick();
    total_cnt++; if ({lsu_state, mem_write_valid, mem_write_address, mem_write_data, mem_read_valid} !== {3'd2, 1'b1, 8'h10, 8'hEE, 1'b0}) $display("[TB] FAIL store_issue: got %h expected %h", {lsu_state, mem_write_valid, mem_write_address, mem_write_data, mem_read_valid}, {3'd2, 1'b1, 8'h10, 8'hEE, 1'b0}); else pass_cnt++;
    mem_read_ready = 1'b1;
    mem_read_data = 8'hAA;
    tick();
    mem_read_ready = 1'b0;
    total_cnt++; if ({lsu_state, mem_write_valid} !== {3'd2, 1'b1}) $display("[TB] FAIL store_wrong_ready: got %h expected %h", {lsu_state, mem_write_valid}, {3'd2, 1'b1}); else pass_cnt++;
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    total_cnt++; if ({lsu_state, mem_write_valid, lsu_out} !== {3'd3, 1'b0, 8'h5C}) $display("[TB] FAIL store_done: got %h expected %h", {lsu_state, mem_write_valid, lsu_out}, {3'd3, 1'b0, 8'h5C}); else pass_cnt++;
    retire();
  endtask

  task automatic test_timeout();
    issue(1'b1, 1'b0, 8'h33, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if ({lsu_state, mem_read_valid} !== {3'd2, 1'b1}) $display("[TB] FAIL timeout_wait_%0d: got %h expected %h", i, {lsu_state, mem_read_valid}, {3'd2, 1'b1}); else pass_cnt++;
    end
    tick();
    total_cnt++; if ({lsu_state, mem_read_valid, lsu_error, lsu_out} !== {3'd4, 1'b0, 1'b1, 8'h5C}) $display("[TB] FAIL timeout_error: got %h expected %h", {lsu_state, mem_read_valid, lsu_error, lsu_out}, {3'd4, 1'b0, 1'b1, 8'h5C}); else pass_cnt++;
    retire();
    total_cnt++; if ({lsu_state, lsu_error} !== {3'd0, 1'b1}) $display("[TB] FAIL error_sticky: got %h expected %h", {lsu_state, lsu_error}, {3'd0, 1'b1}); else pass_cnt++;
    issue(1'b1, 1'b0, 8'h01, 8'h00);
    total_cnt++; if (lsu_error !== 1'b0) $display("[TB] FAIL error_clear: got %b expected 0", lsu_error); else pass_cnt++;
    tick();
    mem_read_ready = 1'b1;
    mem_read_data = 8'h91;
    tick();
    mem_read_ready = 1'b0;
    total_cnt++; if ({lsu_state, lsu_out} !== {3'd3, 8'h91}) $display("[TB] FAIL reload_done: got %h expected %h", {lsu_state, lsu_out}, {3'd3, 8'h91}); else pass_cnt++;
    retire();
  endtask

  task automatic test_both_enables();
    issue(1'b1, 1'b1, 8'h22, 8'h44);
    total_cnt++; if ({lsu_state, lsu_error, mem_read_valid, mem_write_valid} !== {3'd4, 1'b1, 1'b0, 1'b0}) $display("[TB] FAIL both_error: got %h expected %h", {lsu_state, lsu_error, mem_read_valid, mem_write_valid}, {3'd4, 1'b1, 1'b0, 1'b0}); else pass_cnt++;
    tick();
    total_cnt++; if ({lsu_state, mem_read_valid, mem_write_valid} !== {3'd4, 1'b0, 1'b0}) $display("[TB] FAIL both_no_valid: got %h expected %h", {lsu_state, mem_read_valid, mem_write_valid}, {3'd4, 1'b0, 1'b0}); else pass_cnt++;
    retire();
  endtask

  task automatic test_enable_freeze();
    issue(1'b1, 1'b0, 8'h44, 8'h00);
    tick();
    tick();
    enable = 1'b0;
    core_state = 3'b110;
    for (int i = 0; i < 5; i++) begin
      tick();
      total_cnt++; if ({lsu_state, mem_read_valid, mem_read_address} !== {3'd2, 1'b1, 8'h44}) $display("[TB] FAIL freeze_%0d: got %h expected %h", i, {lsu_state, mem_read_valid, mem_read_address}, {3'd2, 1'b1, 8'h44}); else pass_cnt++;
    end
    enable = 1'b1;
    core_state = 3'b000;
    tick();
    tick();
    total_cnt++; if ({lsu_state, mem_read_valid} !== {3'd2, 1'b1}) $display("[TB] FAIL freeze_counter_held: got %h expected %h", {lsu_state, mem_read_valid}, {3'd2, 1'b1}); else pass_cnt++;
    mem_read_ready = 1'b1;
    mem_read_data = 8'h6D;
    tick();
    mem_read_ready = 1'b0;
    total_cnt++; if ({lsu_state, lsu_out, lsu_error} !== {3'd3, 8'h6D, 1'b0}) $display("[TB] FAIL freeze_complete: got %h expected %h", {lsu_state, lsu_out, lsu_error}, {3'd3, 8'h6D, 1'b0}); else pass_cnt++;
    retire();
  endtask

  task automatic test_async_reset();
    issue(1'b1, 1'b0, 8'h55, 8'h00);
    tick();
    total_cnt++; if (mem_read_valid !== 1'b1) $display("[TB] FAIL areset_pre_valid: got %b expected 1", mem_read_valid); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if ({lsu_state, mem_read_valid, mem_read_address, lsu_out, lsu_error} !== {3'd0, 1'b0, 8'h00, 8'h00, 1'b0}) $display("[TB] FAIL areset_outputs: got %h expected 0", {lsu_state, mem_read_valid, mem_read_address, lsu_out, lsu_error}); else pass_cnt++;
    #2 reset = 1'b1;
    tick();
    total_cnt++; if ({lsu_state, mem_read_valid} !== {3'd0, 1'b0}) $display("[TB] FAIL areset_idle: got %h expected 0", {lsu_state, mem_read_valid}); else pass_cnt++;
    issue(1'b0, 1'b1, 8'h3C, 8'hB7);
    tick();
    mem_write_ready = 1'b1;
    tick();
    mem_write_ready = 1'b0;
    total_cnt++; if ({lsu_state, mem_write_address, mem_write_data} !== {3'd3, 8'h3C, 8'hB7}) $display("[TB] FAIL areset_resume: got %h expected %h", {lsu_state, mem_write_address, mem_write_data}, {3'd3, 8'h3C, 8'hB7}); else pass_cnt++;
    retire();
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_both_enables();
    test_enable_freeze();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
